// File: rtl/div_pkg.sv
// Shared types and widths for the two-requester divider arbiter.
// Holds the FSM state enum, datapath widths and the round-robin pick helper.
package div_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 4;
  localparam int Q_W   = 8;
  localparam int R_W   = 5;
  localparam int N_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  // One-hot pick: the requester holding priority wins a tie, otherwise
  // whichever single requester is valid.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                               input logic             prio);
    logic [N_REQ-1:0] pick;
    pick = '0;
    if (valid[prio]) begin
      pick[prio] = 1'b1;
    end else if (valid[~prio]) begin
      pick[~prio] = 1'b1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/divider.sv
// Combinational restoring array divider: q = floor(x/y), r = x mod y.
// A zero divisor gives whatever the array produces (q all ones).
module divider
  import div_pkg::*;
(
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  output logic [Q_W-1:0] q,
  output logic [R_W-1:0] r
);

  logic [R_W-1:0] rem;
  logic [R_W-1:0] y_ext;

  assign y_ext = R_W'(y);

  always_comb begin
    q   = '0;
    rem = '0;
    // NOTE: blocking assignments chain each array row into the next within one evaluation; <= would only see the previous value.
    for (int i = X_W - 1; i >= 0; i--) begin
      rem = {rem[R_W-2:0], x[i]};
      if (rem >= y_ext) begin
        rem  = rem - y_ext;
        q[i] = 1'b1;
      end
    end
    r = rem;
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one combinational divider between two requesters.
// Optional `DIV_ZERO_CHK_EN: y == 0 bypasses the divider and flags rsp_err.
module div_arbiter
  import div_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  logic [X_W-1:0]   x0,
  input  logic [X_W-1:0]   x1,
  input  logic [Y_W-1:0]   y0,
  input  logic [Y_W-1:0]   y1,
  output logic [N_REQ-1:0] rsp_valid,
  input  logic [N_REQ-1:0] rsp_ready,
  output logic [Q_W-1:0]   rsp_q,
  output logic [R_W-1:0]   rsp_r,
  output logic             rsp_err,
  output logic             busy
);

  localparam int             CNT_W     = 4;
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES);

  state_e           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             prio;
  logic             grant;
  logic [X_W-1:0]   x_reg;
  logic [Y_W-1:0]   y_reg;

  logic [N_REQ-1:0] win;
  logic             win_idx;
  logic             accept;
  logic             capture;
  logic             done;

  logic [Q_W-1:0]   div_q;
  logic [R_W-1:0]   div_r;
  logic [Q_W-1:0]   q_cap;
  logic [R_W-1:0]   r_cap;

  assign win     = rr_pick(req_valid, prio);
  assign win_idx = win[1];
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    state_next = state;
    req_ready  = '0;
    rsp_valid  = '0;
    accept     = 1'b0;
    capture    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = win;
        if (|win) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (cnt == CNT_W'(1)) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = N_REQ'(1) << grant;
        if (rsp_ready[grant]) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A reset cycle must not look like a completed handshake to either side.
    if (rst) begin
      req_ready = '0;
      rsp_valid = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      prio  <= 1'b0;
      rsp_q <= '0;
      rsp_r <= '0;
    end else begin
      if (accept) begin
        cnt <= HOLD_INIT;
      end else if (state == CALC) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) begin
        rsp_q <= q_cap;
        rsp_r <= r_cap;
      end
      if (done) begin
        prio <= ~grant;
      end
    end
  end

  // NOTE: operand and grant registers have no reset; they are always loaded on accept before anything reads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_reg <= win_idx ? x1 : x0;
      y_reg <= win_idx ? y1 : y0;
      grant <= win_idx;
    end
  end

  divider u_divider (
    .x (x_reg),
    .y (y_reg),
    .q (div_q),
    .r (div_r)
  );

`ifdef DIV_ZERO_CHK_EN
  logic div_zero;
  logic err_q;

  assign div_zero = (y_reg == '0);
  assign q_cap    = div_zero ? '1 : div_q;
  assign r_cap    = div_zero ? '0 : div_r;
  assign rsp_err  = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (capture) begin
      err_q <= div_zero;
    end
  end
`else
  assign q_cap   = div_q;
  assign r_cap   = div_r;
  assign rsp_err = 1'b0;
`endif

  a_req_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid));
  a_resp_stable: assert property (@(posedge clk) disable iff (rst)
    (state == RESP && !done) |=> ($stable(rsp_q) && $stable(rsp_r) && $stable(rsp_valid)));

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: HOLD_CYCLES = 1 and 3 instances share stimulus,
// each compared every cycle against a cycle-count transaction model plus literal pins.
module tb_div_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [7:0] x0, x1;
  logic [3:0] y0, y1;
  logic [1:0] rsp_ready;

  logic [1:0] d_req_ready [2];
  logic [1:0] d_rsp_valid [2];
  logic [7:0] d_q         [2];
  logic [4:0] d_r         [2];
  logic       d_err       [2];
  logic       d_busy      [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  div_arbiter #(.HOLD_CYCLES(1)) dut_h1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(d_req_ready[0]),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .rsp_valid(d_rsp_valid[0]), .rsp_ready(rsp_ready),
    .rsp_q(d_q[0]), .rsp_r(d_r[0]), .rsp_err(d_err[0]), .busy(d_busy[0])
  );

  div_arbiter #(.HOLD_CYCLES(3)) dut_h3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(d_req_ready[1]),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .rsp_valid(d_rsp_valid[1]), .rsp_ready(rsp_ready),
    .rsp_q(d_q[1]), .rsp_r(d_r[1]), .rsp_err(d_err[1]), .busy(d_busy[1])
  );

  // Transaction model: one outstanding job per instance, timed by cycle count.
  bit         m_active [2];
  int         m_resp_at[2];
  bit         m_g      [2];
  logic [7:0] m_x      [2];
  logic [3:0] m_y      [2];
  bit         m_prio   [2];
  logic [7:0] m_q      [2];
  logic [4:0] m_r      [2];
  bit         m_err    [2];
  bit         m_known  [2];
  int         cyc = 0;

  function automatic int hold_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [1:0] rr_winner(input logic [1:0] v, input bit p);
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_capture(input int k);
    if (m_y[k] == 4'd0) begin
`ifdef DIV_ZERO_CHK_EN
      m_q[k] = 8'hFF; m_r[k] = 5'd0; m_err[k] = 1'b1; m_known[k] = 1'b1;
`else
      m_err[k] = 1'b0; m_known[k] = 1'b0;
`endif
    end else begin
      m_q[k]     = m_x[k] / {4'd0, m_y[k]};
      m_r[k]     = 5'(m_x[k] % {4'd0, m_y[k]});
      m_err[k]   = 1'b0;
      m_known[k] = 1'b1;
    end
  endtask

  task automatic compare_and_advance();
    logic [1:0] e_ready, e_rsp;
    bit         e_busy;
    for (int k = 0; k < 2; k++) begin
      e_ready = 2'b00;
      e_rsp   = 2'b00;
      e_busy  = m_active[k];
      if (!m_active[k]) e_ready = rr_winner(req_valid, m_prio[k]);
      else if (cyc >= m_resp_at[k]) e_rsp[m_g[k]] = 1'b1;
      if (!rst) begin
        check($sformatf("h%0d_req_ready", hold_of(k)), 32'(d_req_ready[k]), 32'(e_ready));
        check($sformatf("h%0d_rsp_valid", hold_of(k)), 32'(d_rsp_valid[k]), 32'(e_rsp));
        check($sformatf("h%0d_busy", hold_of(k)), 32'(d_busy[k]), 32'(e_busy));
        check($sformatf("h%0d_rsp_err", hold_of(k)), 32'(d_err[k]), 32'(m_err[k]));
        if (m_known[k]) begin
          check($sformatf("h%0d_rsp_q", hold_of(k)), 32'(d_q[k]), 32'(m_q[k]));
          check($sformatf("h%0d_rsp_r", hold_of(k)), 32'(d_r[k]), 32'(m_r[k]));
        end
      end
      if (rst) begin
        m_active[k] = 1'b0; m_prio[k] = 1'b0;
        m_q[k] = 8'd0; m_r[k] = 5'd0; m_err[k] = 1'b0; m_known[k] = 1'b1;
      end else if (!m_active[k]) begin
        if (e_ready != 2'b00) begin
          m_g[k]       = e_ready[1];
          m_x[k]       = e_ready[1] ? x1 : x0;
          m_y[k]       = e_ready[1] ? y1 : y0;
          m_resp_at[k] = cyc + 1 + hold_of(k);
          m_active[k]  = 1'b1;
        end
      end else if (cyc + 1 == m_resp_at[k]) begin
        model_capture(k);
      end else if (cyc >= m_resp_at[k] && rsp_ready[m_g[k]]) begin
        m_active[k] = 1'b0;
        m_prio[k]   = !m_g[k];
      end
    end
    cyc++;
  endtask

  task automatic cycle(input logic r, input logic [1:0] v,
                       input logic [7:0] a0, input logic [3:0] b0,
                       input logic [7:0] a1, input logic [3:0] b1,
                       input logic [1:0] rr);
    @(negedge clk);
    rst = r; req_valid = v; x0 = a0; y0 = b0; x1 = a1; y1 = b1; rsp_ready = rr;
    #1;
    compare_and_advance();
  endtask

  task automatic idle(input int n, input logic [1:0] rr);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 8'd0, 4'd1, 8'd0, 4'd1, rr);
  endtask

  task automatic do_reset();
    cycle(1'b1, 2'b00, 8'd0, 4'd1, 8'd0, 4'd1, 2'b00);
  endtask

  logic [1:0] seq_v [8];
  logic [7:0] seq_q [8];
  logic [4:0] seq_r [8];
  int         n_seq;

  initial begin
    rst = 1'b1; req_valid = 2'b00; x0 = '0; x1 = '0; y0 = 4'd1; y1 = 4'd1; rsp_ready = 2'b00;
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 1'b0; m_prio[k] = 1'b0; m_known[k] = 1'b0; m_err[k] = 1'b0;
      m_q[k] = '0; m_r[k] = '0; m_g[k] = 1'b0; m_resp_at[k] = 0;
    end

    // Reset state
    do_reset();
    do_reset();
    idle(1, 2'b11);
    check("rst_busy", 32'(d_busy[0]), 32'd0);
    check("rst_q", 32'(d_q[0]), 32'd0);
    check("rst_rsp_valid", 32'(d_rsp_valid[1]), 32'd0);

    // 200 / 7 on requester 0, HOLD 1: response two cycles after accept
    cycle(1'b0, 2'b01, 8'd200, 4'd7, 8'd0, 4'd1, 2'b11);
    check("r032_accept", 32'(d_req_ready[0]), 32'd1);
    idle(1, 2'b11);
    check("r032_calc_no_rsp", 32'(d_rsp_valid[0]), 32'd0);
    idle(1, 2'b11);
    check("r032_rsp_valid", 32'(d_rsp_valid[0]), 32'd1);
    check("r032_q", 32'(d_q[0]), 32'd28);
    check("r032_r", 32'(d_r[0]), 32'd4);
    idle(6, 2'b11);
    check("r032_h3_q", 32'(d_q[1]), 32'd28);

    // Simultaneous requests after reset, both held: grants alternate from requester 0
    do_reset();
    n_seq = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 2'b11, 8'd255, 4'd15, 8'd100, 4'd9, 2'b11);
      if (i == 0) check("r033_first_grant", 32'(d_req_ready[0]), 32'd1);
      if (d_rsp_valid[0] != 2'b00 && n_seq < 8) begin
        seq_v[n_seq] = d_rsp_valid[0]; seq_q[n_seq] = d_q[0]; seq_r[n_seq] = d_r[0];
        n_seq++;
      end
    end
    check("r033_resp_count_ge4", 32'(n_seq >= 4), 32'd1);
    check("r033_resp0_who", 32'(seq_v[0]), 32'd1);
    check("r033_resp0_q", 32'(seq_q[0]), 32'd17);
    check("r033_resp0_r", 32'(seq_r[0]), 32'd0);
    check("r033_resp1_who", 32'(seq_v[1]), 32'd2);
    check("r033_resp1_q", 32'(seq_q[1]), 32'd11);
    check("r033_resp1_r", 32'(seq_r[1]), 32'd1);
    check("r033_resp2_who", 32'(seq_v[2]), 32'd1);
    check("r033_resp3_who", 32'(seq_v[3]), 32'd2);
    idle(8, 2'b11);

    // Back-pressure in RESP; rsp_ready on the non-granted bit is ignored
    do_reset();
    cycle(1'b0, 2'b10, 8'd0, 4'd1, 8'd50, 4'd3, 2'b00);
    check("r034_accept", 32'(d_req_ready[0]), 32'd2);
    idle(1, 2'b00);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 2'b11, 8'd1, 4'd1, 8'd50, 4'd3, 2'b01);
      check("r034_rsp_valid", 32'(d_rsp_valid[0]), 32'd2);
      check("r034_q", 32'(d_q[0]), 32'd16);
      check("r034_r", 32'(d_r[0]), 32'd2);
      check("r034_req_ready", 32'(d_req_ready[0]), 32'd0);
      check("r034_busy", 32'(d_busy[0]), 32'd1);
    end
    idle(1, 2'b10);
    idle(1, 2'b00);
    check("r034_done_idle", 32'(d_busy[0]), 32'd0);
    idle(3, 2'b11);

    // Divide by zero
    do_reset();
    cycle(1'b0, 2'b01, 8'd77, 4'd0, 8'd0, 4'd1, 2'b11);
    idle(2, 2'b11);
    check("r035_rsp_valid", 32'(d_rsp_valid[0]), 32'd1);
`ifdef DIV_ZERO_CHK_EN
    check("r035_err", 32'(d_err[0]), 32'd1);
    check("r035_q", 32'(d_q[0]), 32'hFF);
    check("r035_r", 32'(d_r[0]), 32'd0);
`else
    check("r035_err", 32'(d_err[0]), 32'd0);
`endif
    idle(6, 2'b11);

    // Reset pulsed while the HOLD 3 instance is in CALC
    do_reset();
    cycle(1'b0, 2'b01, 8'd9, 4'd2, 8'd0, 4'd1, 2'b00);
    idle(1, 2'b00);
    do_reset();
    idle(1, 2'b11);
    check("r036_rsp_valid", 32'(d_rsp_valid[1]), 32'd0);
    check("r036_busy", 32'(d_busy[1]), 32'd0);
    check("r036_q", 32'(d_q[1]), 32'd0);
    check("r036_r", 32'(d_r[1]), 32'd0);
    check("r036_err", 32'(d_err[1]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle(1, 2'b11);
      check("r036_no_rsp", 32'(d_rsp_valid[1]), 32'd0);
    end
    cycle(1'b0, 2'b11, 8'd3, 4'd1, 8'd4, 4'd1, 2'b11);
    check("r036_prio0", 32'(d_req_ready[1]), 32'd1);
    idle(6, 2'b11);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(0, 199) == 0), 2'($urandom),
            8'($urandom), 4'($urandom_range(0, 15)),
            8'($urandom), 4'($urandom_range(0, 15)),
            2'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1: number of cycles (1..15) that operands are held on the shared divider before the result is captured.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  2  per-requester request valid, bit i = requester i.
REQ-005 SHALL have port req_ready  output  2  per-requester request accept, at most one bit set.
REQ-006 SHALL have ports x0, x1  input  8 each  dividends of requesters 0 and 1.
REQ-007 SHALL have ports y0, y1  input  4 each  divisors of requesters 0 and 1.
REQ-008 SHALL have port rsp_valid  output  2  per-requester response valid, at most one bit set.
REQ-009 SHALL have port rsp_ready  input  2  per-requester response accept.
REQ-010 SHALL have port rsp_q  output  8  shared quotient bus.
REQ-011 SHALL have port rsp_r  output  5  shared remainder bus.
REQ-012 SHALL have port rsp_err  output  1  divide-by-zero flag, meaningful only under DIV_ZERO_CHK_EN.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CALC and RESP.
REQ-015 In IDLE, SHALL drive req_ready one-hot to the arbitration winner whenever any req_valid is high, and 2'b00 otherwise.
REQ-016 Arbitration SHALL be round-robin: on a tie, the requester not served last wins; after reset, requester 0 has priority.
REQ-017 On req_valid[g] & req_ready[g], SHALL register x_g, y_g and grant index g, load the hold counter with HOLD_CYCLES, and enter CALC.
REQ-018 req_ready SHALL be 2'b00 in CALC and RESP; requests are not queued.
REQ-019 In CALC, SHALL drive the registered operands to the divider, decrement the counter each cycle, and on the last cycle capture q/r into output registers and enter RESP.
REQ-020 Latency SHALL be: accept at cycle T gives rsp_valid[g] high at T+1+HOLD_CYCLES.
REQ-021 In RESP, SHALL assert only rsp_valid[g] and hold rsp_q/rsp_r/rsp_err stable until rsp_ready[g]; that handshake returns the FSM to IDLE and records g as last served.
REQ-022 SHALL ignore rsp_ready on the non-granted bit.
REQ-023 Throughput SHALL be at most one operation per HOLD_CYCLES+2 cycles; the IDLE cycle after RESP is mandatory.
REQ-024 Results SHALL be q = floor(x/y) and r = x mod y for y != 0, with rsp_r[4] = 0.
REQ-025 Outside RESP, rsp_q/rsp_r/rsp_err SHALL hold their last captured values.

Reset
REQ-026 On rst, SHALL go to IDLE, clear the round-robin pointer (priority to 0), and zero req_ready, rsp_valid, rsp_q, rsp_r, rsp_err, busy and the counter.
REQ-027 Reset in CALC or RESP SHALL abort the transaction with no response issued; rst has priority over every handshake in the same cycle.

Configuration
REQ-028 With DIV_ZERO_CHK_EN defined, y == 0 SHALL bypass the divider: capture q = 8'hFF, r = 5'h00, rsp_err = 1, with latency unchanged.
REQ-029 Without DIV_ZERO_CHK_EN, rsp_err SHALL be tied 0 and y == 0 SHALL return raw divider output.

Structure
REQ-030 Package div_pkg SHALL hold the state enum (IDLE, CALC, RESP), the width constants (X_W = 8, Y_W = 4, Q_W = 8, R_W = 5) and the requester count N_REQ = 2.
REQ-031 SHALL instantiate the team's existing combinational array divider, divider (x 8, y 4, q 8, r 5), once as the shared datapath; no other sub-module.

Verification
REQ-032 req0 x = 200, y = 7, HOLD_CYCLES = 1, rsp_ready tied high -> rsp_valid = 2'b01 two cycles after accept, q = 28, r = 4.
REQ-033 After reset, req0 (255/15) and req1 (100/9) asserted in the same cycle -> req0 served first (q = 17, r = 0), then req1 (q = 11, r = 1); with both held asserted, grants then alternate.
REQ-034 rsp_ready held low for 5 cycles in RESP -> rsp_valid and data stable, req_ready = 0, busy = 1 throughout.
REQ-035 y0 = 0 with DIV_ZERO_CHK_EN -> q = 8'hFF, r = 0, rsp_err = 1; without the macro -> rsp_err = 0.
REQ-036 rst pulsed in CALC with HOLD_CYCLES = 3 -> no rsp_valid, all outputs zero, and the next request is accepted from IDLE with priority to requester 0.
